// File: rtl/wb_sram16.sv
// Wishbone classic slave that maps each 32-bit access onto a 16-bit asynchronous
// SRAM as two half-word phases (HI then LO), each strobed for a programmable cycle count.
module wb_sram16 #(
  parameter int adr_width = 18,
  parameter int latency   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  logic [15:0]          sram_dat,
  output logic [1:0]           sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_RD = CW'(latency - 1);
  localparam logic [CW-1:0] LAST_WR = CW'(latency);

  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_HI, WR_LO, ACK} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [adr_width-2:0]  adr_reg, req_adr;
  logic [3:0]            sel_reg, req_sel;
  logic [31:0]           wdat_reg, req_dat;
  logic [15:0]           rd_hi_reg;

  logic [31:0]           dat_o_reg;
  logic                  ack_reg;
  logic [adr_width-1:0]  sram_adr_reg, sram_adr_next;
  logic [1:0]            be_n_reg, be_n_next;
  logic                  ce_n_reg, oe_n_reg, we_n_reg, we_n_next;
  logic                  drive_reg;
  logic [15:0]           dout_reg, dout_next;
  logic                  rd_next, wr_next, lo_next;

  // Byte-offset bits and address bits beyond the SRAM are intentionally ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (wb_cyc_i && wb_stb_i) state_next = wb_we_i ? WR_HI : RD_HI;
      end
      RD_HI: if (cnt_reg == LAST_RD) begin state_next = RD_LO; cnt_next = '0; end
      RD_LO: if (cnt_reg == LAST_RD) begin state_next = ACK;   cnt_next = '0; end
      WR_HI: if (cnt_reg == LAST_WR) begin state_next = WR_LO; cnt_next = '0; end
      WR_LO: if (cnt_reg == LAST_WR) begin state_next = ACK;   cnt_next = '0; end
      ACK: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Master abandoning the cycle aborts whatever phase is in progress.
    if (state_reg != IDLE && !wb_cyc_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // Request fields come straight from the bus on the accepting edge, else from the latch.
  always_comb begin
    if (state_reg == IDLE) begin
      req_adr = wb_adr_i[adr_width:2];
      req_sel = wb_sel_i;
      req_dat = wb_dat_i;
    end else begin
      req_adr = adr_reg;
      req_sel = sel_reg;
      req_dat = wdat_reg;
    end
  end

  // SRAM controls are registered from the next state so they line up with the state register.
  always_comb begin
    rd_next       = (state_next == RD_HI) || (state_next == RD_LO);
    wr_next       = (state_next == WR_HI) || (state_next == WR_LO);
    lo_next       = (state_next == RD_LO) || (state_next == WR_LO);
    sram_adr_next = sram_adr_reg;
    if (rd_next || wr_next) sram_adr_next = {req_adr, lo_next};
    be_n_next = 2'b11;
    if (rd_next)                    be_n_next = 2'b00;
    else if (state_next == WR_HI)   be_n_next = ~req_sel[3:2];
    else if (state_next == WR_LO)   be_n_next = ~req_sel[1:0];
    dout_next = lo_next ? req_dat[15:0] : req_dat[31:16];
    we_n_next = !(wr_next && (cnt_next != LAST_WR));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      adr_reg      <= '0;
      sel_reg      <= '0;
      wdat_reg     <= '0;
      rd_hi_reg    <= '0;
      dat_o_reg    <= '0;
      ack_reg      <= 1'b0;
      sram_adr_reg <= '0;
      be_n_reg     <= 2'b11;
      ce_n_reg     <= 1'b1;
      oe_n_reg     <= 1'b1;
      we_n_reg     <= 1'b1;
      drive_reg    <= 1'b0;
      dout_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      adr_reg      <= req_adr;
      sel_reg      <= req_sel;
      wdat_reg     <= req_dat;
      ack_reg      <= (state_next == ACK);
      sram_adr_reg <= sram_adr_next;
      be_n_reg     <= be_n_next;
      ce_n_reg     <= !(rd_next || wr_next);
      oe_n_reg     <= !rd_next;
      we_n_reg     <= we_n_next;
      drive_reg    <= wr_next;
      dout_reg     <= dout_next;
      // HI half is staged so an aborted read leaves wb_dat_o untouched.
      if (state_reg == RD_HI && cnt_reg == LAST_RD && wb_cyc_i) rd_hi_reg <= sram_dat;
      if (state_reg == RD_LO && cnt_reg == LAST_RD && wb_cyc_i) dat_o_reg <= {rd_hi_reg, sram_dat};
    end
  end

  assign wb_dat_o  = dat_o_reg;
  assign wb_ack_o  = ack_reg;
  assign sram_adr  = sram_adr_reg;
  assign sram_be_n = be_n_reg;
  assign sram_ce_n = ce_n_reg;
  assign sram_oe_n = oe_n_reg;
  assign sram_we_n = we_n_reg;
  assign sram_dat  = drive_reg ? dout_reg : {16{1'bz}};

endmodule
